// File: rtl/clk_en_gen.sv
// Cascaded clock-enable generator with programmable last-stage ratio.
// Produces one-cycle strobes and registered 50% square clocks per stage.
module clk_en_gen #(
    parameter int NUM_STAGES  = 3,
    parameter int PRE_DIV     = 2,
    parameter int STAGE_RATIO = 4,
    parameter int CNT_W       = 8,
    parameter int PHASE_W     = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic                  sync,
    input  logic [CNT_W-1:0]      cfg_ratio,
    input  logic                  cfg_load,
    output logic [NUM_STAGES-1:0] stage_en,
    output logic [NUM_STAGES-1:0] stage_clk,
    output logic [PHASE_W-1:0]    phase,
    output logic                  cfg_busy
);

    localparam int LAST = NUM_STAGES - 1;

    logic [CNT_W-1:0]      cnt_q [NUM_STAGES];
    logic [CNT_W-1:0]      cnt_d [NUM_STAGES];
    logic [CNT_W-1:0]      ratio [NUM_STAGES];
    logic [NUM_STAGES-1:0] clk_d;
    logic [CNT_W-1:0]      active_ratio;
    logic [CNT_W-1:0]      pending_ratio;
    logic [CNT_W-1:0]      clamp_ratio;
    logic                  apply;

    always_comb begin
        for (int i = 0; i < NUM_STAGES; i++) begin
            if (i == 0)
                ratio[i] = CNT_W'(PRE_DIV);
            else if (i == LAST)
                ratio[i] = active_ratio;
            else
                ratio[i] = CNT_W'(STAGE_RATIO);
        end
    end

    // Each stage advances only on the strobe of the stage below it.
    always_comb begin
        logic run;
        logic hit;
        run      = enable & ~sync;
        stage_en = '0;
        clk_d    = '0;
        for (int i = 0; i < NUM_STAGES; i++) begin
            hit = (cnt_q[i] == ratio[i] - CNT_W'(1));
            if (sync)
                cnt_d[i] = '0;
            else if (run)
                cnt_d[i] = hit ? '0 : cnt_q[i] + CNT_W'(1);
            else
                cnt_d[i] = cnt_q[i];
            clk_d[i]    = (cnt_d[i] < (ratio[i] >> 1));
            stage_en[i] = run & hit;
            run         = run & hit;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NUM_STAGES; i++)
                cnt_q[i] <= '0;
            stage_clk <= '0;
        end else begin
            for (int i = 0; i < NUM_STAGES; i++)
                cnt_q[i] <= cnt_d[i];
            if (sync)
                stage_clk <= '1;
            else if (enable)
                stage_clk <= clk_d;
        end
    end

    assign clamp_ratio = (cfg_ratio < CNT_W'(2)) ? CNT_W'(2) : cfg_ratio;
    assign apply       = stage_en[LAST] | sync;

    // A load that lands on a boundary skips the pending stage entirely.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            active_ratio  <= CNT_W'(STAGE_RATIO);
            pending_ratio <= CNT_W'(STAGE_RATIO);
            cfg_busy      <= 1'b0;
        end else if (cfg_load) begin
            pending_ratio <= clamp_ratio;
            if (apply) begin
                active_ratio <= clamp_ratio;
                cfg_busy     <= 1'b0;
            end else begin
                cfg_busy <= 1'b1;
            end
        end else if (apply && cfg_busy) begin
            active_ratio <= pending_ratio;
            cfg_busy     <= 1'b0;
        end
    end

    generate
        if (PHASE_W <= CNT_W) begin : g_phase_trunc
            assign phase = cnt_q[LAST][PHASE_W-1:0];
        end else begin : g_phase_ext
            assign phase = {{(PHASE_W-CNT_W){1'b0}}, cnt_q[LAST]};
        end
    endgenerate

endmodule

// File: tb/tb_clk_en_gen.sv
// Scoreboard bench for clk_en_gen: expected strobe cycles are queued,
// a negedge monitor pops them as the DUT raises stage_en.
module tb_clk_en_gen;

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic       sync;
    logic [7:0] cfg_ratio;
    logic       cfg_load;
    logic [2:0] stage_en;
    logic [2:0] stage_clk;
    logic [3:0] phase;
    logic       cfg_busy;

    int tick = 0;
    int t0 = 0;
    int n_chk = 0;
    int n_err = 0;
    bit chk1 = 0;
    int exp1[$];
    int exp2[$];

    clk_en_gen dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .sync      (sync),
        .cfg_ratio (cfg_ratio),
        .cfg_load  (cfg_load),
        .stage_en  (stage_en),
        .stage_clk (stage_clk),
        .phase     (phase),
        .cfg_busy  (cfg_busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) tick <= tick + 1;

    always @(negedge clk) begin
        int e;
        if (reset === 1'b1) begin
            if (stage_en[2]) begin
                n_chk++;
                if (exp2.size() == 0) begin
                    n_err++;
                    $display("FAIL se2_strobe: unexpected at cycle %0d", tick - t0);
                end else begin
                    e = exp2.pop_front();
                    if (e != tick) begin
                        n_err++;
                        $display("FAIL se2_strobe: got cycle %0d expected %0d",
                                 tick - t0, e - t0);
                    end
                end
            end
            if (chk1 && stage_en[1]) begin
                n_chk++;
                if (exp1.size() == 0) begin
                    n_err++;
                    $display("FAIL se1_strobe: unexpected at cycle %0d", tick - t0);
                end else begin
                    e = exp1.pop_front();
                    if (e != tick) begin
                        n_err++;
                        $display("FAIL se1_strobe: got cycle %0d expected %0d",
                                 tick - t0, e - t0);
                    end
                end
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)",
                     name, act, exp, tick - t0);
        end
    endtask

    // Advance to 1ns after the edge that starts relative cycle n.
    task automatic at(input int n);
        while (tick - t0 < n) begin
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        reset     = 1'b0;
        enable    = 1'b1;
        sync      = 1'b0;
        cfg_ratio = 8'd0;
        cfg_load  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_stage_en", 32'(stage_en), 0);
        chk("rst_stage_clk", 32'(stage_clk), 0);
        chk("rst_phase", 32'(phase), 0);
        chk("rst_busy", 32'(cfg_busy), 0);

        reset = 1'b1;
        t0    = tick;
        chk1  = 1'b1;
        exp1.push_back(t0 + 7);
        exp1.push_back(t0 + 15);
        exp1.push_back(t0 + 23);
        exp1.push_back(t0 + 31);
        exp2.push_back(t0 + 31);
        exp2.push_back(t0 + 63);
        exp2.push_back(t0 + 111);
        exp2.push_back(t0 + 159);
        exp2.push_back(t0 + 175);
        exp2.push_back(t0 + 191);

        at(1);   chk("en0_c1", 32'(stage_en[0]), 1);
        at(2);   chk("en0_c2", 32'(stage_en[0]), 0);
        at(10);  chk("phase_c10", 32'(phase), 1);
        at(20);  chk("sclk2_c20", 32'(stage_clk[2]), 0);
        at(26);  chk("phase_c26", 32'(phase), 3);
        at(33);  chk1 = 1'b0;
        at(40);  chk("sclk2_c40", 32'(stage_clk[2]), 1);
        cfg_ratio = 8'd6;
        cfg_load  = 1'b1;
        at(41);  cfg_load = 1'b0;
        chk("busy_c41", 32'(cfg_busy), 1);
        at(50);  chk("sclk2_c50", 32'(stage_clk[2]), 0);
        at(63);  chk("busy_c63", 32'(cfg_busy), 1);
        at(64);  chk("busy_c64", 32'(cfg_busy), 0);
        at(105); chk("phase_c105", 32'(phase), 5);

        at(159);
        cfg_ratio = 8'd1;
        cfg_load  = 1'b1;
        at(160); cfg_load = 1'b0;
        chk("busy_wrapload", 32'(cfg_busy), 0);

        at(200);
        cfg_ratio = 8'd5;
        cfg_load  = 1'b1;
        at(201); cfg_load = 1'b0;
        chk("busy_c201", 32'(cfg_busy), 1);
        at(205);
        chk("s1_queue_empty", 32'(exp2.size()), 0);
        #2 reset = 1'b0;
        #1;
        chk("arst_stage_en", 32'(stage_en), 0);
        chk("arst_stage_clk", 32'(stage_clk), 0);
        chk("arst_phase", 32'(phase), 0);
        chk("arst_busy", 32'(cfg_busy), 0);
        repeat (2) @(posedge clk);
        #1;

        reset = 1'b1;
        t0    = tick;
        exp2.push_back(t0 + 31);
        at(30);  chk("r2_phase_c30", 32'(phase), 3);
        at(45);
        sync = 1'b1;
        #1;
        chk("sync_no_strobe", 32'(stage_en), 0);
        at(46);  sync = 1'b0;
        chk("sync_phase", 32'(phase), 0);
        chk("sync_stage_clk", 32'(stage_clk), 7);
        exp2.push_back(t0 + 77);

        at(80);
        cfg_ratio = 8'd3;
        cfg_load  = 1'b1;
        at(81);  cfg_load = 1'b0;
        chk("busy_c81", 32'(cfg_busy), 1);
        exp2.push_back(t0 + 109);
        exp2.push_back(t0 + 133);
        at(85);  sync = 1'b1;
        at(86);  sync = 1'b0;
        chk("busy_sync_apply", 32'(cfg_busy), 0);

        at(150);
        enable = 1'b0;
        exp2.push_back(t0 + 167);
        exp2.push_back(t0 + 191);
        at(155);
        chk("frz_phase", 32'(phase), 2);
        chk("frz_stage_en", 32'(stage_en), 0);
        at(160); enable = 1'b1;

        at(195);
        cfg_ratio = 8'd7;
        cfg_load  = 1'b1;
        exp2.push_back(t0 + 215);
        exp2.push_back(t0 + 255);
        at(196); cfg_load = 1'b0;
        at(197);
        cfg_ratio = 8'd5;
        cfg_load  = 1'b1;
        at(198); cfg_load = 1'b0;
        chk("busy_c198", 32'(cfg_busy), 1);
        at(216); chk("busy_c216", 32'(cfg_busy), 0);
        at(260);
        chk("end_queue2_empty", 32'(exp2.size()), 0);
        chk("end_queue1_empty", 32'(exp1.size()), 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
